reg_wb_ctrl: RTL and testbench

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

---
 rtl/legv8_pkg.sv | 13 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/reg_wb_ctrl.sv | 101 ++++++++++
 tb/tb_reg_wb_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 register-file constants and the write-back request record.
package legv8_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 64;
  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests; head is visible whenever not empty.
module wb_fifo
  import legv8_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t        slots [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back arbiter: MEM loads vs. queued ALU results, with
// starvation relief for the ALU queue and an outstanding-load scoreboard.
module reg_wb_ctrl #(
  parameter int DATA_W      = 64,
  parameter int ALU_Q_DEPTH = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              ld_issue,
  input  logic [4:0]        ld_reg,
  output logic              reg_write_c,
  output logic [4:0]        wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       pending
);

  import legv8_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starve;
  logic          mem_fire;
  logic          alu_fire;
  logic          alu_direct;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  wb_req_t       q_din;
  wb_req_t       q_head;
  logic          sel_valid;
  wb_req_t       sel;
  logic [31:0]   pend_set;
  logic [31:0]   pend_clr;

  wb_fifo #(.DEPTH(ALU_Q_DEPTH)) u_alu_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // MEM normally wins; the queue head retires whenever MEM does not transfer,
  // and a fresh ALU beat bypasses the queue only when the queue is empty.
  always_comb begin
    starve     = (starve_cnt == SW'(STARVE_MAX)) && !q_empty;
    mem_ready  = !rst && !starve;
    mem_fire   = mem_valid && mem_ready;
    q_pop      = !rst && !q_empty && !mem_fire;
    alu_ready  = !rst && (!q_full || q_pop);
    alu_fire   = alu_valid && alu_ready;
    alu_direct = alu_fire && q_empty && !mem_fire;
    q_push     = alu_fire && !alu_direct;
    q_din      = '{idx: alu_reg, data: alu_data};
    sel_valid  = mem_fire || q_pop || alu_direct;
    sel        = '{idx: alu_reg, data: alu_data};
    if (mem_fire)
      sel = '{idx: mem_reg, data: mem_data};
    else if (q_pop)
      sel = q_head;
    pend_set = (ld_issue && (ld_reg != XZR_IDX)) ? (32'd1 << ld_reg) : 32'd0;
    pend_clr = mem_fire ? (32'd1 << mem_reg) : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_c <= 1'b0;
      wr_reg      <= '0;
      wr_data     <= '0;
      pending     <= '0;
      starve_cnt  <= '0;
    end else begin
      reg_write_c <= sel_valid && (sel.idx != XZR_IDX);
      if (sel_valid && (sel.idx != XZR_IDX)) begin
        wr_reg  <= sel.idx;
        wr_data <= sel.data;
      end
      if (q_pop || alu_direct || q_empty)
        starve_cnt <= '0;
      else if (mem_fire)
        starve_cnt <= starve_cnt + 1'b1;
      // Set is applied after clear so a coincident issue keeps the bit.
      pending <= ((pending & ~pend_clr) | pend_set) & 32'h7FFF_FFFF;
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: expected writes go into a scoreboard queue
// and a negedge monitor pops and compares every register-file write.
module tb_reg_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [63:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_reg;
  logic [63:0] mem_data;
  logic        ld_issue;
  logic [4:0]  ld_reg;
  logic        reg_write_c;
  logic [4:0]  wr_reg;
  logic [63:0] wr_data;
  logic [31:0] pending;

  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  reg_wb_ctrl #(.DATA_W(64), .ALU_Q_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_reg     (alu_reg),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_reg     (mem_reg),
    .mem_data    (mem_data),
    .ld_issue    (ld_issue),
    .ld_reg      (ld_reg),
    .reg_write_c (reg_write_c),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                               input logic mv, input logic [4:0] mr, input logic [63:0] md,
                               input logic li, input logic [4:0] lr);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    ld_issue  = li; ld_reg  = lr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  task automatic pushExp(input logic [4:0] r, input logic [63:0] d);
    exp_t e;
    e.r = r;
    e.d = d;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reg_write_c === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got reg %0d data %0h expected no write", wr_reg, wr_data);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("wb_reg", 64'(wr_reg), 64'(e.r));
        checkOutput("wb_data", wr_data, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] expAluRdy;
    logic [6:0] expMemRdy;
    int mi;
    int ai;

    rst = 1'b1;
    idle();

    // Reset state.
    @(negedge clk);
    checkOutput("rst_alu_ready", 64'(alu_ready), 64'd0);
    checkOutput("rst_mem_ready", 64'(mem_ready), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_write", 64'(reg_write_c), 64'd0);
    checkOutput("rst_pending", 64'(pending), 64'd0);
    checkOutput("rst_wr_data", wr_data, 64'd0);
    nextCycle();
    rst = 1'b0;

    // Single direct ALU beat, written on the next cycle only.
    applyStimulus(1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    pushExp(5'd3, 64'h55);
    @(negedge clk);
    checkOutput("alu_ready_first", 64'(alu_ready), 64'd1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("alu_write_c", 64'(reg_write_c), 64'd1);
    checkOutput("alu_wr_reg", 64'(wr_reg), 64'd3);
    nextCycle();
    @(negedge clk);
    checkOutput("alu_write_drop", 64'(reg_write_c), 64'd0);
    checkOutput("hold_wr_data", wr_data, 64'h55);

    // Load issue then matching MEM return five cycles later.
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("pending7_set", 64'(pending), 64'h80);
    for (int i = 0; i < 4; i++) nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hAA, 1'b0, 5'd0);
    pushExp(5'd7, 64'hAA);
    @(negedge clk);
    checkOutput("mem_ready_idle", 64'(mem_ready), 64'd1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("mem7_write_c", 64'(reg_write_c), 64'd1);
    checkOutput("pending7_clr", 64'(pending), 64'd0);

    // MEM and ALU contend; ALU queue fills, starvation relief after 4 MEM wins.
    for (int k = 0; k < 5; k++) pushExp(5'(10 + k), 64'h100 + 64'(k));
    pushExp(5'd1, 64'hA0);
    pushExp(5'd15, 64'h105);
    pushExp(5'd2, 64'hA1);
    pushExp(5'd3, 64'hA2);
    expAluRdy = 7'b0100011;
    expMemRdy = 7'b1011111;
    mi = 0;
    ai = 0;
    nextCycle();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(ai < 3, 5'(1 + ai), 64'hA0 + 64'(ai),
                    mi < 6, 5'(10 + mi), 64'h100 + 64'(mi), 1'b0, 5'd0);
      @(negedge clk);
      checkOutput($sformatf("arb_alu_ready_c%0d", c), 64'(alu_ready), 64'(expAluRdy[c]));
      checkOutput($sformatf("arb_mem_ready_c%0d", c), 64'(mem_ready), 64'(expMemRdy[c]));
      if (mem_valid && mem_ready) mi++;
      if (alu_valid && alu_ready) ai++;
      nextCycle();
    end
    idle();
    checkOutput("arb_mem_beats", 64'(mi), 64'd6);
    checkOutput("arb_alu_beats", 64'(ai), 64'd3);
    for (int w = 0; w < 20 && expQ.size() != 0; w++) nextCycle();
    checkOutput("arb_drained", 64'(expQ.size()), 64'd0);
    checkOutput("arb_pending", 64'(pending), 64'd0);

    // XZR writes and XZR load issue are silently absorbed.
    applyStimulus(1'b1, 5'd31, 64'h31, 1'b1, 5'd31, 64'h32, 1'b1, 5'd31);
    @(negedge clk);
    checkOutput("xzr_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("xzr_mem_ready", 64'(mem_ready), 64'd1);
    nextCycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("xzr_no_write_%0d", i), 64'(reg_write_c), 64'd0);
      checkOutput($sformatf("xzr_pending_%0d", i), 64'(pending), 64'd0);
      nextCycle();
    end

    // Coincident issue and MEM return of reg 9: set wins, write still happens.
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99, 1'b1, 5'd9);
    pushExp(5'd9, 64'h99);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("coinc_pending9", 64'(pending), 64'h200);
    checkOutput("coinc_wr_reg", 64'(wr_reg), 64'd9);
    nextCycle();

    // Fill queue with PENDING[4] set, stall a third ALU beat, then reset.
    applyStimulus(1'b1, 5'd5, 64'h5, 1'b1, 5'd20, 64'h200, 1'b1, 5'd4);
    pushExp(5'd20, 64'h200);
    nextCycle();
    applyStimulus(1'b1, 5'd6, 64'h6, 1'b1, 5'd21, 64'h201, 1'b0, 5'd0);
    pushExp(5'd21, 64'h201);
    @(negedge clk);
    checkOutput("fill_pending4", 64'(pending), 64'h210);
    nextCycle();
    applyStimulus(1'b1, 5'd7, 64'h7, 1'b1, 5'd22, 64'h202, 1'b0, 5'd0);
    pushExp(5'd22, 64'h202);
    @(negedge clk);
    checkOutput("full_alu_stall", 64'(alu_ready), 64'd0);
    nextCycle();
    idle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_alu_ready", 64'(alu_ready), 64'd0);
    checkOutput("midrst_mem_ready", 64'(mem_ready), 64'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_pending", 64'(pending), 64'd0);
    checkOutput("postrst_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("postrst_mem_ready", 64'(mem_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("postrst_no_write_%0d", i), 64'(reg_write_c), 64'd0);
      nextCycle();
      @(negedge clk);
    end
    checkOutput("final_scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
